// File: rtl/data_sram_responder_pkg.sv
// Shared constants and helpers for the data SRAM responder.
// Holds the default MMIO base and RAM size, the MMIO register offsets,
// the decoded register selector type and the byte-lane merge helper.
package data_sram_responder_pkg;

  localparam int unsigned RamAwDefault    = 10;
  localparam logic [31:0] ConfBaseDefault = 32'hbfaf_0000;

  localparam logic [15:0] OffLed     = 16'h0000;
  localparam logic [15:0] OffSwitch  = 16'h0004;
  localparam logic [15:0] OffNum     = 16'h0008;
  localparam logic [15:0] OffTimer   = 16'h000c;
  localparam logic [15:0] OffScratch = 16'h0010;

  typedef enum logic [2:0] {
    RegNone,
    RegLed,
    RegSwitch,
    RegNum,
    RegTimer,
    RegScratch
  } mmio_reg_e;

  // Byte lane i takes new_val when be[i] is set, otherwise keeps old_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_bw_ram.sv
// Single-port synchronous RAM with four byte-write enables.
// Ports: clk_i clock; en_i access enable; we_i byte strobes (0 = read);
// addr_i word index; wdata_i write data; rdata_o registered read data,
// updated only on read accesses. No reset on array or read register.
module bw_ram #(
  parameter int unsigned Aw = 10
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  localparam int unsigned Depth = 1 << Aw;

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i == 4'b0000) begin
        rdata_q <= mem_q[addr_i];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU data SRAM interface: local byte-writable RAM plus
// a small MMIO register file (LED, switch, number display, timer, scratch).
// Ports: clk/reset (async, active-high); data_sram_en/we/addr/wdata request;
// data_sram_rdata read data, valid the cycle after a read request;
// switch board input (asynchronous); led and num_data register outputs.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned RAM_AW    = RamAwDefault,
  parameter logic [31:0] CONF_BASE = ConfBaseDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  logic        req_rd, req_wr, is_mmio, ram_en;
  logic [15:0] mmio_off;
  mmio_reg_e   reg_sel;
  logic [31:0] ram_rdata, mmio_rdata, led_merged;

  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] scratch_q, scratch_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic        sel_ram_q, sel_ram_d;

  logic unused_addr_lo;
  assign unused_addr_lo = ^data_sram_addr[1:0];

  assign req_rd   = data_sram_en && (data_sram_we == 4'b0000);
  assign req_wr   = data_sram_en && (data_sram_we != 4'b0000);
  assign is_mmio  = (data_sram_addr[31:16] == CONF_BASE[31:16]);
  assign mmio_off = {data_sram_addr[15:2], 2'b00};
  // Requests seen while reset is held must not touch the RAM either.
  assign ram_en   = data_sram_en && !is_mmio && !reset;

  bw_ram #(
    .Aw (RAM_AW)
  ) u_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (data_sram_we),
    .addr_i  (data_sram_addr[RAM_AW+1:2]),
    .wdata_i (data_sram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    reg_sel = RegNone;
    case (mmio_off)
      OffLed:     reg_sel = RegLed;
      OffSwitch:  reg_sel = RegSwitch;
      OffNum:     reg_sel = RegNum;
      OffTimer:   reg_sel = RegTimer;
      OffScratch: reg_sel = RegScratch;
      default:    reg_sel = RegNone;
    endcase
  end

  // Timer reads return the value before this edge's increment.
  always_comb begin
    mmio_rdata = 32'h0;
    unique case (reg_sel)
      RegLed:     mmio_rdata = {16'h0, led_q};
      RegSwitch:  mmio_rdata = {24'h0, sw_sync_q};
      RegNum:     mmio_rdata = num_q;
      RegTimer:   mmio_rdata = timer_q;
      RegScratch: mmio_rdata = scratch_q;
      default:    mmio_rdata = 32'h0;
    endcase
  end

  assign led_merged = byte_merge({16'h0, led_q}, data_sram_wdata, data_sram_we);

  always_comb begin
    led_d        = led_q;
    num_d        = num_q;
    scratch_d    = scratch_q;
    timer_d      = timer_q + 32'd1;
    mmio_rdata_d = mmio_rdata_q;
    sel_ram_d    = sel_ram_q;
    if (req_wr && is_mmio) begin
      unique case (reg_sel)
        RegLed:     led_d     = led_merged[15:0];
        RegNum:     num_d     = byte_merge(num_q, data_sram_wdata, data_sram_we);
        RegTimer:   timer_d   = byte_merge(timer_q, data_sram_wdata, data_sram_we);
        RegScratch: scratch_d = byte_merge(scratch_q, data_sram_wdata, data_sram_we);
        default:    ;
      endcase
    end
    // Select is captured with the request so it lines up with the RAM's
    // registered output; both hold across idle and write cycles.
    if (req_rd) begin
      sel_ram_d = !is_mmio;
      if (is_mmio) mmio_rdata_d = mmio_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q        <= '0;
      num_q        <= '0;
      timer_q      <= '0;
      scratch_q    <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      mmio_rdata_q <= '0;
      sel_ram_q    <= 1'b0;
    end else begin
      led_q        <= led_d;
      num_q        <= num_d;
      timer_q      <= timer_d;
      scratch_q    <= scratch_d;
      sw_meta_q    <= switch;
      sw_sync_q    <= sw_meta_q;
      mmio_rdata_q <= mmio_rdata_d;
      sel_ram_q    <= sel_ram_d;
    end
  end

  // With the select cleared by reset the unreset RAM output is masked,
  // so rdata reads 0 immediately on reset.
  assign data_sram_rdata = sel_ram_q ? ram_rdata : mmio_rdata_q;
  assign led             = led_q;
  assign num_data        = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  localparam int RamAw    = 10;
  localparam int RamWords = 1 << RamAw;
  localparam logic [31:0] Conf = 32'hbfaf_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [7:0]  sw = 8'h0;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [31:0] num_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sram_responder #(
    .RAM_AW    (RamAw),
    .CONF_BASE (Conf)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch          (sw),
    .led             (led),
    .num_data        (num_data)
  );

  // Reference model state
  logic [31:0] m_ram [RamWords];
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_num = 32'h0;
  logic [31:0] m_timer = 32'h0;
  logic [31:0] m_scratch = 32'h0;
  logic [31:0] m_led = 32'h0;
  logic [7:0]  m_sw1 = 8'h0;
  logic [7:0]  m_sw2 = 8'h0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rdata = 0; m_num = 0; m_timer = 0; m_scratch = 0; m_led = 0; m_sw1 = 0; m_sw2 = 0;
  endtask

  always @(posedge clk) begin : mdl
    logic [31:0] nxt_timer;
    logic [15:0] off;
    int idx;
    if (!reset) begin
      nxt_timer = m_timer + 1;
      off = addr[15:0] & 16'hfffc;
      idx = int'(addr[RamAw+1:2]);
      if (en) begin
        if (addr[31:16] == Conf[31:16]) begin
          if (we != 0) begin
            case (off)
              16'h0000: m_led = merge(m_led, wdata, we) & 32'h0000_ffff;
              16'h0008: m_num = merge(m_num, wdata, we);
              16'h000c: nxt_timer = merge(m_timer, wdata, we);
              16'h0010: m_scratch = merge(m_scratch, wdata, we);
              default: ;
            endcase
          end else begin
            case (off)
              16'h0000: m_rdata = m_led;
              16'h0004: m_rdata = {24'h0, m_sw2};
              16'h0008: m_rdata = m_num;
              16'h000c: m_rdata = m_timer;
              16'h0010: m_rdata = m_scratch;
              default:  m_rdata = 32'h0;
            endcase
          end
        end else if (we != 0) begin
          m_ram[idx] = merge(m_ram[idx], wdata, we);
        end else begin
          m_rdata = m_ram[idx];
        end
      end
      m_timer = nxt_timer;
      m_sw2 = m_sw1;
      m_sw1 = sw;
    end
  end

  always @(negedge clk) begin
    check("cmp_rdata", rdata, m_rdata);
    check("cmp_led", {16'h0, led}, m_led);
    check("cmp_num", num_data, m_num);
  end

  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic rand_cycle();
    logic [31:0] a;
    logic [15:0] offs [8];
    int kind;
    offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000c, 16'h0010, 16'h0020, 16'h0014, 16'h8000};
    if ($urandom_range(15) == 0) sw = 8'($urandom);
    kind = $urandom_range(3);
    a = $urandom;
    if (kind == 0) begin
      a = {Conf[31:16], offs[$urandom_range(7)] | 16'($urandom_range(3))};
    end else begin
      if (a[31:16] == Conf[31:16]) a[31] = ~a[31];
      if (kind == 1) a[11:2] = 10'($urandom_range(7));
    end
    cyc($urandom_range(7) != 0, ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom), a, $urandom);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_num", num_data, 32'h0);
    reset = 1'b0;

    cyc(1, 4'hf, 32'h0000_0040, 32'hdead_beef);
    cyc(1, 4'h0, 32'h0000_0040, 32'h0);
    check("raw_read", rdata, 32'hdead_beef);
    cyc(0, 4'h0, 32'h0, 32'h0);
    cyc(0, 4'h0, 32'h0, 32'h0);
    check("rdata_held", rdata, 32'hdead_beef);

    cyc(1, 4'hf, 32'h0000_0044, 32'h1122_3344);
    cyc(1, 4'b0010, 32'h0000_0044, 32'h0000_aa00);
    cyc(1, 4'h0, 32'h0000_0044, 32'h0);
    check("byte_lane", rdata, 32'h1122_aa44);

    cyc(1, 4'hf, 32'h0000_1000, 32'h5a5a_5a5a);
    cyc(1, 4'h0, 32'h0000_0000, 32'h0);
    check("ram_alias", rdata, 32'h5a5a_5a5a);

    cyc(1, 4'hf, Conf | 32'h0, 32'hffff_1234);
    check("led_out", {16'h0, led}, 32'h0000_1234);
    cyc(1, 4'h0, Conf | 32'h0, 32'h0);
    check("led_read", rdata, 32'h0000_1234);
    cyc(1, 4'h0, Conf | 32'h20, 32'h0);
    check("unmapped_read", rdata, 32'h0);
    cyc(1, 4'hf, Conf | 32'h4, 32'hffff_ffff);
    cyc(1, 4'h0, Conf | 32'h4, 32'h0);
    check("switch_ro", rdata, 32'h0);

    cyc(1, 4'hf, Conf | 32'hc, 32'hffff_fffe);
    cyc(0, 4'h0, 32'h0, 32'h0);
    cyc(1, 4'h0, Conf | 32'hc, 32'h0);
    check("timer_a", rdata, 32'hffff_ffff);
    cyc(1, 4'h0, Conf | 32'hc, 32'h0);
    check("timer_wrap", rdata, 32'h0000_0000);

    sw = 8'ha5;
    cyc(0, 4'h0, 32'h0, 32'h0);
    cyc(0, 4'h0, 32'h0, 32'h0);
    cyc(1, 4'h0, Conf | 32'h4, 32'h0);
    check("switch_sync", rdata, 32'h0000_00a5);

    // Fill RAM so every random read has a known expectation.
    for (int i = 0; i < RamWords; i++) cyc(1, 4'hf, 32'(i) << 2, $urandom);
    for (int i = 0; i < 3000; i++) rand_cycle();

    cyc(1, 4'hf, Conf | 32'h8, 32'h1234_5678);
    check("num_out", num_data, 32'h1234_5678);
    cyc(1, 4'h0, Conf | 32'h8, 32'h0);
    check("num_read", rdata, 32'h1234_5678);
    en = 1'b1; we = 4'h0; addr = 32'h0000_0040;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_rdata", rdata, 32'h0);
    check("async_rst_num", num_data, 32'h0);
    @(negedge clk);
    en = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("dropped_read", rdata, 32'h0);

    for (int i = 0; i < 500; i++) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
